pc_update_sequencer: RTL and testbench

//  Multicycle FSM that owns every PC update: drives the 3-bit PC-source mux select, pc_write and epc_write.

---
 rtl/pc_update_sequencer_pkg.sv | 41 ++++
 rtl/pc_update_sequencer_if.sv | 28 ++
 rtl/pc_update_sequencer_exc_priority_enc.sv | 18 +
 rtl/pc_update_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_update_sequencer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pc_update_sequencer_pkg.sv
// Shared encodings for the PC update sequencer: request kinds, PC-source mux selects,
// exception causes, FSM states and default handler-pointer addresses.
package pc_update_sequencer_pkg;

  typedef enum logic [2:0] {
    KIND_INC  = 3'd0,
    KIND_BEQ  = 3'd1,
    KIND_BNE  = 3'd2,
    KIND_JUMP = 3'd3,
    KIND_JR   = 3'd4,
    KIND_RTE  = 3'd5
  } ctl_kind_e;

  typedef enum logic [2:0] {
    SRC_LSOUT       = 3'd0,
    SRC_ALU_RESULT  = 3'd1,
    SRC_ALU_OUT     = 3'd2,
    SRC_SHIFT_LEFT2 = 3'd3,
    SRC_EPC         = 3'd4
  } pc_src_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_OVF    = 2'd2,
    CAUSE_DIV0   = 2'd3
  } exc_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_EXC_EPC  = 3'd2,
    ST_EXC_MEM  = 3'd3,
    ST_EXC_LOAD = 3'd4
  } seq_state_e;

  localparam logic [31:0] DEF_VEC_OPCODE = 32'd253;
  localparam logic [31:0] DEF_VEC_OVF    = 32'd254;
  localparam logic [31:0] DEF_VEC_DIV0   = 32'd255;

endpackage

// File: rtl/pc_update_sequencer_if.sv
// Control/exception request bus into the sequencer and its PC/EPC/memory control outputs.
// master = main control + datapath side, slave = sequencer.
interface pc_update_sequencer_if;
  logic        ctl_valid;
  logic        ctl_ready;
  logic [2:0]  ctl_kind;
  logic        zero;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [2:0]  pc_source;
  logic        pc_write;
  logic        epc_write;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [1:0]  exc_cause;
  logic        busy;

  modport master (
    output ctl_valid, ctl_kind, zero, exc_opcode, exc_ovf, exc_div0,
    input  ctl_ready, pc_source, pc_write, epc_write, mem_rd, mem_addr, exc_cause, busy
  );

  modport slave (
    input  ctl_valid, ctl_kind, zero, exc_opcode, exc_ovf, exc_div0,
    output ctl_ready, pc_source, pc_write, epc_write, mem_rd, mem_addr, exc_cause, busy
  );
endinterface

// File: rtl/pc_update_sequencer_exc_priority_enc.sv
// Exception flag priority encoder (opcode > ovf > div0), purely combinational, no backpressure.
module pc_update_sequencer_exc_priority_enc
  import pc_update_sequencer_pkg::*;
(
  input  logic       i_opcode,
  input  logic       i_ovf,
  input  logic       i_div0,
  output logic [1:0] o_cause
);

  always_comb begin
    o_cause = CAUSE_NONE;
    if (i_opcode)    o_cause = CAUSE_OPCODE;
    else if (i_ovf)  o_cause = CAUSE_OVF;
    else if (i_div0) o_cause = CAUSE_DIV0;
  end

endmodule

// File: rtl/pc_update_sequencer.sv
// Owns every PC/EPC update: one-cycle ISSUE per accepted request (ready again 2 cycles after accept),
// exception entry in MEM_LAT+2 cycles; ctl_ready stays low while busy or an exception is pending.
module pc_update_sequencer
  import pc_update_sequencer_pkg::*;
#(
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVF    = DEF_VEC_OVF,
  parameter logic [31:0] VEC_DIV0   = DEF_VEC_DIV0
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_update_sequencer_if.slave bus
);

  seq_state_e r_state;
  seq_state_e w_next;
  logic [1:0] r_pend;
  logic [1:0] r_exc_cause;
  logic [2:0] r_cnt;
  logic [2:0] r_kind;
  logic       r_zero;
  logic [1:0] w_cause;
  logic       w_exc_any;
  logic       w_rsv;

  assign w_rsv     = (r_state == ST_ISSUE) && (r_kind > KIND_RTE);
  assign w_exc_any = (w_cause != CAUSE_NONE);

  // Merge live flags with the sticky cause so a pending entry can only be promoted, never lost.
  pc_update_sequencer_exc_priority_enc u_enc (
    .i_opcode (bus.exc_opcode | (r_pend == CAUSE_OPCODE) | w_rsv),
    .i_ovf    (bus.exc_ovf    | (r_pend == CAUSE_OVF)),
    .i_div0   (bus.exc_div0   | (r_pend == CAUSE_DIV0)),
    .o_cause  (w_cause)
  );

  function automatic logic [31:0] vec_addr(input logic [1:0] cause);
    case (cause)
      CAUSE_OPCODE: vec_addr = VEC_OPCODE;
      CAUSE_OVF:    vec_addr = VEC_OVF;
      CAUSE_DIV0:   vec_addr = VEC_DIV0;
      default:      vec_addr = 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pend      <= CAUSE_NONE;
      r_exc_cause <= CAUSE_NONE;
      r_cnt       <= 3'd0;
      r_kind      <= 3'd0;
      r_zero      <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_exc_any) begin
        r_exc_cause <= w_cause;
        r_pend      <= CAUSE_NONE;
      end else begin
        r_pend <= w_cause;
      end
      if ((r_state == ST_IDLE) && !w_exc_any && bus.ctl_valid) begin
        r_kind <= bus.ctl_kind;
        r_zero <= bus.zero;
      end
      if (r_state == ST_EXC_EPC)
        r_cnt <= 3'(MEM_LAT - 1);
      else if ((r_state == ST_EXC_MEM) && (r_cnt != 3'd0))
        r_cnt <= r_cnt - 3'd1;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.ctl_ready = 1'b0;
    bus.pc_source = SRC_ALU_RESULT;
    bus.pc_write  = 1'b0;
    bus.epc_write = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.exc_cause = r_exc_cause;
    bus.busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        bus.ctl_ready = !w_exc_any;
        if (w_exc_any)          w_next = ST_EXC_EPC;
        else if (bus.ctl_valid) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_next = ST_IDLE;
        case (r_kind)
          KIND_INC:  bus.pc_write = 1'b1;
          KIND_BEQ: begin
            bus.pc_source = SRC_ALU_OUT;
            bus.pc_write  = r_zero;
          end
          KIND_BNE: begin
            bus.pc_source = SRC_ALU_OUT;
            bus.pc_write  = !r_zero;
          end
          KIND_JUMP: begin
            bus.pc_source = SRC_SHIFT_LEFT2;
            bus.pc_write  = 1'b1;
          end
          KIND_JR:   bus.pc_write = 1'b1;
          KIND_RTE: begin
            bus.pc_source = SRC_EPC;
            bus.pc_write  = 1'b1;
          end
          default:   bus.pc_write = 1'b0;
        endcase
      end
      ST_EXC_EPC: begin
        bus.epc_write = 1'b1;
        w_next        = ST_EXC_MEM;
      end
      ST_EXC_MEM: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = vec_addr(r_exc_cause);
        if (r_cnt == 3'd0) w_next = ST_EXC_LOAD;
      end
      ST_EXC_LOAD: begin
        bus.pc_source = SRC_LSOUT;
        bus.pc_write  = 1'b1;
        w_next        = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Directed bench: per-cycle vector table on a MEM_LAT=1 instance, hand sequences on a MEM_LAT=3 instance.
module tb_pc_update_sequencer;
  import pc_update_sequencer_pkg::*;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_update_sequencer_if if1();
  pc_update_sequencer_if if3();

  pc_update_sequencer u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  pc_update_sequencer #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        vld;
    logic [2:0]  kind;
    logic        zero;
    logic [2:0]  exc;   // {opcode, ovf, div0}
    logic        rdy;
    logic [2:0]  src;
    logic        pcw;
    logic        epcw;
    logic        mrd;
    logic [31:0] addr;
    logic [1:0]  cause;
    logic        busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic vld, logic [2:0] kind, logic zero, logic [2:0] exc,
                              logic rdy, logic [2:0] src, logic pcw, logic epcw, logic mrd,
                              logic [31:0] addr, logic [1:0] cause, logic busy);
    vec_t v;
    v.vld = vld; v.kind = kind; v.zero = zero; v.exc = exc;
    v.rdy = rdy; v.src = src; v.pcw = pcw; v.epcw = epcw; v.mrd = mrd;
    v.addr = addr; v.cause = cause; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic rdy, input logic [2:0] src, input logic pcw,
                      input logic epcw, input logic mrd, input logic [31:0] addr,
                      input logic [1:0] cause, input logic busy);
    chk({tag, ".ctl_ready"}, 32'(if3.ctl_ready), 32'(rdy));
    chk({tag, ".pc_source"}, 32'(if3.pc_source), 32'(src));
    chk({tag, ".pc_write"},  32'(if3.pc_write),  32'(pcw));
    chk({tag, ".epc_write"}, 32'(if3.epc_write), 32'(epcw));
    chk({tag, ".mem_rd"},    32'(if3.mem_rd),    32'(mrd));
    chk({tag, ".mem_addr"},  if3.mem_addr,       addr);
    chk({tag, ".exc_cause"}, 32'(if3.exc_cause), 32'(cause));
    chk({tag, ".busy"},      32'(if3.busy),      32'(busy));
  endtask

  task automatic clr3();
    if3.ctl_valid = 1'b0; if3.ctl_kind = 3'd0; if3.zero = 1'b0;
    if3.exc_opcode = 1'b0; if3.exc_ovf = 1'b0; if3.exc_div0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  initial begin
    int mrd_cnt;
    // vld kind zero exc | rdy src pcw epcw mrd addr cause busy
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 0 idle
    vt.push_back(mk(T, KIND_BEQ,  T, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 1 accept BEQ z=1
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd2, T, F, F, 32'd0,   2'd0, T)); // 2 issue taken
    vt.push_back(mk(T, KIND_BEQ,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 3 accept BEQ z=0
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd2, F, F, F, 32'd0,   2'd0, T)); // 4 not taken
    vt.push_back(mk(T, KIND_BNE,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 5 accept BNE z=0
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd2, T, F, F, 32'd0,   2'd0, T)); // 6 taken
    vt.push_back(mk(T, KIND_JR,   F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 7 accept JR
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, T, F, F, 32'd0,   2'd0, T)); // 8
    vt.push_back(mk(T, KIND_RTE,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 9 accept RTE
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd4, T, F, F, 32'd0,   2'd0, T)); // 10
    vt.push_back(mk(T, KIND_INC,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 11 accept INC
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, T, F, F, 32'd0,   2'd0, T)); // 12
    vt.push_back(mk(T, KIND_JUMP, F, 3'b011,  F, 3'd1, F, F, F, 32'd0,   2'd0, F)); // 13 ovf+div0 beat valid
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, T, F, 32'd0,   2'd2, T)); // 14 EXC_EPC
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, F, T, 32'd254, 2'd2, T)); // 15 EXC_MEM
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd0, T, F, F, 32'd0,   2'd2, T)); // 16 EXC_LOAD
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd2, F)); // 17 idle, cause held
    vt.push_back(mk(T, KIND_JUMP, F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd2, F)); // 18 accept JUMP
    vt.push_back(mk(F, KIND_INC,  F, 3'b001,  F, 3'd3, T, F, F, 32'd0,   2'd2, T)); // 19 div0 during ISSUE
    vt.push_back(mk(T, KIND_INC,  F, 3'b000,  F, 3'd1, F, F, F, 32'd0,   2'd2, F)); // 20 pending blocks accept
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, T, F, 32'd0,   2'd3, T)); // 21
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, F, T, 32'd255, 2'd3, T)); // 22
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd0, T, F, F, 32'd0,   2'd3, T)); // 23
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd3, F)); // 24
    vt.push_back(mk(T, 3'd6,      F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd3, F)); // 25 accept reserved
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, F, F, 32'd0,   2'd3, T)); // 26 no PC write
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, F, F, 32'd0,   2'd3, F)); // 27 opcode pending
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, T, F, 32'd0,   2'd1, T)); // 28
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd1, F, F, T, 32'd253, 2'd1, T)); // 29
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  F, 3'd0, T, F, F, 32'd0,   2'd1, T)); // 30
    vt.push_back(mk(F, KIND_INC,  F, 3'b000,  T, 3'd1, F, F, F, 32'd0,   2'd1, F)); // 31

    reset = 1'b0;
    if1.ctl_valid = 1'b0; if1.ctl_kind = 3'd0; if1.zero = 1'b0;
    if1.exc_opcode = 1'b0; if1.exc_ovf = 1'b0; if1.exc_div0 = 1'b0;
    clr3();
    repeat (2) @(negedge clk);
    chk("rst1.pc_source", 32'(if1.pc_source), 32'd1);
    chk("rst1.pc_write",  32'(if1.pc_write),  32'd0);
    chk("rst1.epc_write", 32'(if1.epc_write), 32'd0);
    chk("rst1.mem_rd",    32'(if1.mem_rd),    32'd0);
    chk("rst1.mem_addr",  if1.mem_addr,       32'd0);
    chk("rst1.exc_cause", 32'(if1.exc_cause), 32'd0);
    chk("rst1.busy",      32'(if1.busy),      32'd0);
    chk3("rst3", T, 3'd1, F, F, F, 32'd0, 2'd0, F);
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      if1.ctl_valid  = vt[i].vld;
      if1.ctl_kind   = vt[i].kind;
      if1.zero       = vt[i].zero;
      if1.exc_opcode = vt[i].exc[2];
      if1.exc_ovf    = vt[i].exc[1];
      if1.exc_div0   = vt[i].exc[0];
      @(negedge clk);
      chk($sformatf("v%0d.ctl_ready", i), 32'(if1.ctl_ready), 32'(vt[i].rdy));
      chk($sformatf("v%0d.pc_source", i), 32'(if1.pc_source), 32'(vt[i].src));
      chk($sformatf("v%0d.pc_write",  i), 32'(if1.pc_write),  32'(vt[i].pcw));
      chk($sformatf("v%0d.epc_write", i), 32'(if1.epc_write), 32'(vt[i].epcw));
      chk($sformatf("v%0d.mem_rd",    i), 32'(if1.mem_rd),    32'(vt[i].mrd));
      chk($sformatf("v%0d.mem_addr",  i), if1.mem_addr,       vt[i].addr);
      chk($sformatf("v%0d.exc_cause", i), 32'(if1.exc_cause), 32'(vt[i].cause));
      chk($sformatf("v%0d.busy",      i), 32'(if1.busy),      32'(vt[i].busy));
    end

    // MEM_LAT=3 invalid-opcode entry: EPC at +1, three reads at 253, PC load at +5.
    mrd_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      clr3();
      if3.exc_opcode = (c == 0);
      @(negedge clk);
      if (if3.mem_rd) mrd_cnt++;
      case (c)
        0:       chk3($sformatf("lat3.c%0d", c), F, 3'd1, F, F, F, 32'd0,   2'd0, F);
        1:       chk3($sformatf("lat3.c%0d", c), F, 3'd1, F, T, F, 32'd0,   2'd1, T);
        2, 3, 4: chk3($sformatf("lat3.c%0d", c), F, 3'd1, F, F, T, 32'd253, 2'd1, T);
        5:       chk3($sformatf("lat3.c%0d", c), F, 3'd0, T, F, F, 32'd0,   2'd1, T);
        default: chk3($sformatf("lat3.c%0d", c), T, 3'd1, F, F, F, 32'd0,   2'd1, F);
      endcase
    end
    chk("lat3.mem_rd_cycles", 32'(mrd_cnt), 32'd3);

    // Reset dropped in the middle of EXC_MEM.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      clr3();
      if3.exc_ovf = (c == 0);
      @(negedge clk);
    end
    chk3("mid.before", F, 3'd1, F, F, T, 32'd254, 2'd2, T);
    #2 reset = 1'b0;
    #1 chk3("mid.async", T, 3'd1, F, F, F, 32'd0, 2'd0, F);
    @(posedge clk); #1;
    chk3("mid.edge", T, 3'd1, F, F, F, 32'd0, 2'd0, F);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk3($sformatf("mid.after%0d", c), T, 3'd1, F, F, F, 32'd0, 2'd0, F);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
